id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 93 +++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: single-entry valid/ready stage with operand forwarding,
// illegal-opcode folding and a saturating back-pressure counter.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [31:0] Rs1_Data,
  input  logic [31:0] Rs2_Data,
  input  logic [4:0]  Rs1_Addr,
  input  logic [4:0]  Rs2_Addr,
  input  logic [4:0]  Rd_Addr,
  input  logic [31:0] Imm,
  input  logic        ALUSrc,
  input  logic [3:0]  ALU_Control_In,
  input  logic        RegWrite_In,
  input  logic        ExMem_RegWrite,
  input  logic [4:0]  ExMem_Rd,
  input  logic [31:0] ExMem_Result,
  input  logic        MemWb_RegWrite,
  input  logic [4:0]  MemWb_Rd,
  input  logic [31:0] MemWb_Result,
  input  logic        Flush,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [31:0] Op1,
  output logic [31:0] Op2,
  output logic [3:0]  ALU_Control,
  output logic [4:0]  Rd_Out,
  output logic        RegWrite_Out,
  output logic [15:0] Stall_Count
);

  logic        capture;
  logic [31:0] fwd_rs1;
  logic [31:0] fwd_rs2;
  logic [3:0]  alu_legal;

  assign In_Ready = !Out_Valid || Out_Ready;
  assign capture  = In_Valid && In_Ready && !Flush;

  // EX/MEM result is newer than MEM/WB, so it is checked first; x0 never forwards.
  always_comb begin
    fwd_rs1 = Rs1_Data;
    if (ExMem_RegWrite && (ExMem_Rd == Rs1_Addr) && (Rs1_Addr != '0))
      fwd_rs1 = ExMem_Result;
    else if (MemWb_RegWrite && (MemWb_Rd == Rs1_Addr) && (Rs1_Addr != '0))
      fwd_rs1 = MemWb_Result;
  end

  always_comb begin
    fwd_rs2 = Rs2_Data;
    if (ExMem_RegWrite && (ExMem_Rd == Rs2_Addr) && (Rs2_Addr != '0))
      fwd_rs2 = ExMem_Result;
    else if (MemWb_RegWrite && (MemWb_Rd == Rs2_Addr) && (Rs2_Addr != '0))
      fwd_rs2 = MemWb_Result;
  end

  always_comb begin
    alu_legal = ALU_Control_In;
    if (ALU_Control_In > 4'd10)
      alu_legal = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Out_Valid    <= 1'b0;
      Op1          <= '0;
      Op2          <= '0;
      ALU_Control  <= '0;
      Rd_Out       <= '0;
      RegWrite_Out <= 1'b0;
      Stall_Count  <= '0;
    end else begin
      if (Flush) begin
        Out_Valid <= 1'b0;
      end else if (capture) begin
        Out_Valid    <= 1'b1;
        Op1          <= fwd_rs1;
        Op2          <= ALUSrc ? Imm : fwd_rs2;
        ALU_Control  <= alu_legal;
        Rd_Out       <= Rd_Addr;
        RegWrite_Out <= RegWrite_In;
      end else if (Out_Ready) begin
        Out_Valid <= 1'b0;
      end

      if (Out_Valid && !Out_Ready && !Flush && (Stall_Count != '1))
        Stall_Count <= Stall_Count + 16'd1;
    end
  end

endmodule
